muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the HI/LO arithmetic resources in the EX stage. It accepts one multiply or divide operation at a time from EX and holds the pipeline with `stall_o` until the result is ready. It drives the external pipelined multiplier (fixed latency, clock enable) and the external iterative divider (start/done handshake), and performs the MADD/MSUB accumulation. It then presents one cycle of HI/LO and GPR write data.

## Interface
- `MUL_LAT`, default 6: number of clock-enabled cycles the multiplier needs from operand presentation to a valid product.
- `clk_i`  in  1: clock. Single clock domain.
- `rst_n_i`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: EX holds a muldiv op. Held high until `stall_o` drops.
- `op_i`  in  4: `muldiv_op_e`. One of MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, DIV, DIVU.
- `rs_i`, `rt_i`  in  32: source operands.
- `hi_i`, `lo_i`  in  32: forwarded current HI/LO.
- `flush_i`  in  1: kills the op in EX, from a flush or an exception.
- `mul_a_o`, `mul_b_o`  out  32: registered multiplier operands.
- `mul_signed_o`, `mul_ce_o`, `mul_sclr_o`  out  1: multiplier controls.
- `mul_p_i`  in  64: multiplier product.
- `div_a_o`, `div_b_o`  out  32: registered divider operands.
- `div_signed_o`, `div_start_o`, `div_abort_o`  out  1: divider controls.
- `div_done_i`  in  1: divider completion pulse.
- `div_quot_i`, `div_rem_i`  in  32: divider results.
- `stall_o`  out  1: hold IF/ID/EX.
- `busy_o`  out  1: state ≠ IDLE.
- `hi_we_o`, `lo_we_o`, `gpr_we_o`  out  1: write strobes.
- `hi_o`, `lo_o`, `gpr_o`  out  32: write data.

## Operation
- **States:** IDLE, MUL_WAIT, DIV_WAIT, DONE.
- **IDLE, `start_i` & !`flush_i`:**
  - Register `op`, `rs`, `rt`, `hi`, `lo`.
  - A mul-class op goes to MUL_WAIT with `cnt` = 1.
  - DIV/DIVU with `rt` = 0 goes directly to DONE with the div result forced to quot = 32'hFFFFFFFF, rem = `rs`.
  - Any other DIV/DIVU goes to DIV_WAIT.
  - `stall_o` = `start_i` in IDLE, combinationally.
- **MUL_WAIT:**
  - `mul_ce_o` = 1 and `cnt` increments each cycle.
  - At `cnt` == `MUL_LAT` → DONE.
  - `mul_signed_o` = op ∈ {MULT, MUL, MADD, MSUB}.
- **DIV_WAIT:**
  - `div_start_o` is a one-cycle pulse in the first DIV_WAIT cycle.
  - `div_done_i` in any DIV_WAIT cycle, including the first, captures quot/rem into result registers → DONE.
  - There is no timeout.
- **DONE:**
  - Lasts exactly one cycle with `stall_o` = 0, then → IDLE. Strobes are active only in DONE and only when !`flush_i`.
  - MULT/MULTU: HI = P[63:32], LO = P[31:0].
  - MADD(U): {HI,LO} = {hi,lo} + P, modulo 2^64.
  - MSUB(U): {HI,LO} = {hi,lo} − P, modulo 2^64.
  - MUL: `gpr_we_o` = 1 and `gpr_o` = P[31:0]; HI/LO are not written.
  - DIV(U): LO = quot, HI = rem.
- **`flush_i` in any state:**
  - Next state is IDLE.
  - `mul_sclr_o` = 1 while busy.
  - `div_abort_o` = 1 in DIV_WAIT.
  - No write strobes and no start acceptance in that cycle.
- `mul_ce_o`, `div_start_o` and all strobes are 0 in IDLE.

## Timing
- **Reset:** state IDLE, `cnt` 0, all operand/result registers 0, every output 0.
- **Mul-class latency:** accept edge at end of cycle 0; MUL_WAIT cycles 1..`MUL_LAT`; DONE at cycle `MUL_LAT`+1.
  - `stall_o` is high for `MUL_LAT`+1 cycles.
  - `mul_ce_o` is low in DONE, so P holds.
- **Divide latency:** 1 + (cycles to `div_done_i`) + 1 stalled cycles, then DONE.
- **Divide by zero:** the accept cycle plus DONE; 1 stall cycle.
- **Back-to-back ops:** DONE → IDLE → accept. One IDLE cycle separates consecutive ops; it is stalled because `start_i` is high.
- **Flush on the accept edge:** the op is dropped and the state stays IDLE.
- **Flush in DONE:** writes are suppressed.
- **Reset mid-operation:** immediate return to IDLE; the external units are cleared by their own reset.

## Structure
- `muldiv_pkg`:
  - `muldiv_op_e` (4-bit) and `muldiv_state_e`.
  - Helper functions `is_mul_op`, `is_signed_op`, `is_acc_op`.
  - `MUL_LAT_DEFAULT`.
- No sub-module. The multiplier and divider are instantiated by the parent and wired to this block.

## Test plan
- **MULT timing:** `MUL_LAT`=6, MULT rs=-3 (32'hFFFFFFFD), rt=7 → `stall_o` high 7 cycles; DONE writes HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- **MADDU wrap:** hi=32'hFFFFFFFF, lo=32'hFFFFFFFF, rs=1, rt=1 → HI=0, LO=0.
- **MUL to GPR:** MUL 32'h10000 × 32'h10000 → `gpr_we_o`=1, `gpr_o`=0; `hi_we_o`=`lo_we_o`=0.
- **DIVU handshake and divide by zero:**
  - DIVU 100/7 with `div_done_i` 10 cycles after `div_start_o` → LO=14, HI=2, and `div_start_o` pulses exactly once.
  - DIV rt=0, rs=5 → DONE one cycle after accept with LO=32'hFFFFFFFF, HI=5.
- **Flush:**
  - `flush_i` in MUL_WAIT cycle 3 → IDLE next cycle, `mul_sclr_o`=1, no strobes.
  - `flush_i` in DIV_WAIT → `div_abort_o`=1.
- **Async reset:** deassert `rst_n_i` mid DIV_WAIT → state and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int MUL_LAT_DEFAULT = 6;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MUL   = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_DIV   = 4'd8,
    OP_DIVU  = 4'd9
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } muldiv_state_e;

  function automatic logic is_mul_op(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL) ||
           (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) ||
           (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  function automatic logic is_acc_op(input muldiv_op_e op);
    return (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one multiply/divide op from EX through the external multiplier/divider,
// holding the pipeline until a single DONE cycle presents the HI/LO/GPR writes.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_signed_o,
  output logic        mul_ce_o,
  output logic        mul_sclr_o,
  input  logic [63:0] mul_p_i,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_signed_o,
  output logic        div_start_o,
  output logic        div_abort_o,
  input  logic        div_done_i,
  input  logic [31:0] div_quot_i,
  input  logic [31:0] div_rem_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic        gpr_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] gpr_o
);

  localparam int               CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      rem_q, rem_d;
  logic             div_first_q, div_first_d;

  muldiv_op_e  op_in;
  logic [63:0] acc_sum;
  logic [63:0] acc_dif;
  logic [63:0] acc_res;

  assign op_in   = muldiv_op_e'(op_i);
  assign acc_sum = {hi_q, lo_q} + mul_p_i;
  assign acc_dif = {hi_q, lo_q} - mul_p_i;
  assign acc_res = ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) ? acc_dif : acc_sum;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    div_first_d = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_d = op_in;
            rs_d = rs_i;
            rt_d = rt_i;
            hi_d = hi_i;
            lo_d = lo_i;
            if (is_mul_op(op_in)) begin
              state_d = ST_MUL_WAIT;
              cnt_d   = CNT_W'(1);
            end else if (is_div_op(op_in)) begin
              // Divide by zero never reaches the divider; the result is architecturally fixed.
              if (rt_i == 32'd0) begin
                state_d = ST_DONE;
                quot_d  = 32'hFFFF_FFFF;
                rem_d   = rs_i;
              end else begin
                state_d     = ST_DIV_WAIT;
                div_first_d = 1'b1;
              end
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DIV_WAIT: begin
          if (div_done_i) begin
            quot_d  = div_quot_i;
            rem_d   = div_rem_i;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NONE;
      rs_q        <= '0;
      rt_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      div_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      div_first_q <= div_first_d;
    end
  end

  assign mul_a_o      = rs_q;
  assign mul_b_o      = rt_q;
  assign div_a_o      = rs_q;
  assign div_b_o      = rt_q;
  assign mul_signed_o = is_mul_op(op_q) & is_signed_op(op_q);
  assign div_signed_o = is_div_op(op_q) & is_signed_op(op_q);
  assign busy_o       = (state_q != ST_IDLE);
  assign mul_sclr_o   = flush_i & busy_o;

  always_comb begin
    stall_o     = 1'b0;
    mul_ce_o    = 1'b0;
    div_start_o = 1'b0;
    div_abort_o = 1'b0;
    hi_we_o     = 1'b0;
    lo_we_o     = 1'b0;
    gpr_we_o    = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    gpr_o       = '0;
    case (state_q)
      ST_IDLE: stall_o = start_i;
      ST_MUL_WAIT: begin
        stall_o  = 1'b1;
        mul_ce_o = 1'b1;
      end
      ST_DIV_WAIT: begin
        stall_o     = 1'b1;
        div_start_o = div_first_q & ~flush_i;
        div_abort_o = flush_i;
      end
      ST_DONE: begin
        // Product holds here because mul_ce_o is low, so it can be used directly.
        if (!flush_i) begin
          if (is_acc_op(op_q)) begin
            hi_we_o = 1'b1;
            lo_we_o = 1'b1;
            hi_o    = acc_res[63:32];
            lo_o    = acc_res[31:0];
          end else begin
            case (op_q)
              OP_MULT, OP_MULTU: begin
                hi_we_o = 1'b1;
                lo_we_o = 1'b1;
                hi_o    = mul_p_i[63:32];
                lo_o    = mul_p_i[31:0];
              end
              OP_MUL: begin
                gpr_we_o = 1'b1;
                gpr_o    = mul_p_i[31:0];
              end
              OP_DIV, OP_DIVU: begin
                hi_we_o = 1'b1;
                lo_we_o = 1'b1;
                hi_o    = rem_q;
                lo_o    = quot_q;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl with behavioural multiplier/divider and a write scoreboard.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int LAT = 6;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] rs_i, rt_i, hi_i, lo_i;
  logic [31:0] mul_a_o, mul_b_o, div_a_o, div_b_o;
  logic        mul_signed_o, mul_ce_o, mul_sclr_o;
  logic [63:0] mul_p_i;
  logic        div_signed_o, div_start_o, div_abort_o, div_done_i;
  logic [31:0] div_quot_i, div_rem_i;
  logic        stall_o, busy_o, hi_we_o, lo_we_o, gpr_we_o;
  logic [31:0] hi_o, lo_o, gpr_o;

  always #5 clk_i = ~clk_i;

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_signed_o(mul_signed_o),
    .mul_ce_o(mul_ce_o), .mul_sclr_o(mul_sclr_o), .mul_p_i(mul_p_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_signed_o(div_signed_o),
    .div_start_o(div_start_o), .div_abort_o(div_abort_o), .div_done_i(div_done_i),
    .div_quot_i(div_quot_i), .div_rem_i(div_rem_i), .stall_o(stall_o),
    .busy_o(busy_o), .hi_we_o(hi_we_o), .lo_we_o(lo_we_o), .gpr_we_o(gpr_we_o),
    .hi_o(hi_o), .lo_o(lo_o), .gpr_o(gpr_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pipelined multiplier: product appears after LAT clock-enabled edges.
  logic [63:0] mpipe [LAT];
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else if (mul_sclr_o) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else if (mul_ce_o) begin
      if (mul_signed_o)
        mpipe[0] <= {{32{mul_a_o[31]}}, mul_a_o} * {{32{mul_b_o[31]}}, mul_b_o};
      else
        mpipe[0] <= {32'b0, mul_a_o} * {32'b0, mul_b_o};
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_p_i = mpipe[LAT-1];

  // Iterative divider: done div_delay cycles after start (0 = same cycle as start).
  function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (s) return {32'(sa / sb), 32'(sa % sb)};
    return {a / b, a % b};
  endfunction

  int          div_delay = 10;
  int          dcnt;
  logic        dbusy;
  logic [31:0] dq, dr;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dbusy <= 1'b0;
      dcnt  <= 0;
    end else if (div_abort_o) begin
      dbusy <= 1'b0;
    end else if (div_start_o && div_delay > 0) begin
      dbusy     <= 1'b1;
      dcnt      <= 1;
      {dq, dr}  <= divide(div_a_o, div_b_o, div_signed_o);
    end else if (dbusy) begin
      if (dcnt == div_delay) dbusy <= 1'b0;
      else dcnt <= dcnt + 1;
    end
  end

  always_comb begin
    if (div_delay == 0) begin
      div_done_i = div_start_o;
      {div_quot_i, div_rem_i} = divide(div_a_o, div_b_o, div_signed_o);
    end else begin
      div_done_i = dbusy && (dcnt == div_delay);
      div_quot_i = dq;
      div_rem_i  = dr;
    end
  end

  // Scoreboard of expected write cycles.
  typedef struct packed {
    logic        hw, lw, gw;
    logic [31:0] hi, lo, gpr;
  } wr_t;
  wr_t exp_q[$];
  int  start_pulses = 0;

  always @(negedge clk_i) begin
    wr_t e;
    #2;
    if (div_start_o) start_pulses++;
    if (hi_we_o || lo_we_o || gpr_we_o) begin
      chk("write_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("hi_we", hi_we_o, e.hw);
        chk("lo_we", lo_we_o, e.lw);
        chk("gpr_we", gpr_we_o, e.gw);
        if (e.hw) chk("hi", hi_o, e.hi);
        if (e.lw) chk("lo", lo_o, e.lo);
        if (e.gw) chk("gpr", gpr_o, e.gpr);
      end
    end
  end

  function automatic wr_t hl(input logic [31:0] hi, input logic [31:0] lo);
    return '{hw: 1'b1, lw: 1'b1, gw: 1'b0, hi: hi, lo: lo, gpr: 32'd0};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo,
                        input int exp_stall, input int exp_starts);
    int stalls;
    int s0;
    stalls = 0;
    s0     = start_pulses;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt; hi_i = hi; lo_i = lo;
    #1;
    while (stall_o && stalls < 300) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    chk({tag, "_stall"}, stalls, exp_stall);
    chk({tag, "_done_busy"}, busy_o, 1);
    chk({tag, "_done_ce"}, mul_ce_o, 0);
    @(negedge clk_i);
    start_i = 1'b0;
    #3;
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_starts"}, start_pulses - s0, exp_starts);
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 4'd0;
    rs_i = '0; rt_i = '0; hi_i = '0; lo_i = '0;
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_ce", mul_ce_o, 0);
    chk("rst_div_start", div_start_o, 0);
    chk("rst_strobes", {hi_we_o, lo_we_o, gpr_we_o}, 0);
    chk("rst_opnds", {mul_a_o, div_b_o}, 0);
    chk("rst_data", {hi_o, lo_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    exp_q.push_back(hl(32'hFFFF_FFFF, 32'hFFFF_FFEB));
    run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, LAT + 1, 0);
    exp_q.push_back(hl(32'hFFFF_FFFE, 32'h0000_0001));
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, LAT + 1, 0);
    exp_q.push_back(hl(32'h0, 32'h0));
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT + 1, 0);
    exp_q.push_back(hl(32'h0, 32'd4));
    run_op("madd", OP_MADD, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, LAT + 1, 0);
    exp_q.push_back(hl(32'hFFFF_FFFF, 32'hFFFF_FFFF));
    run_op("msub", OP_MSUB, 32'd2, 32'd3, 32'd0, 32'd5, LAT + 1, 0);
    exp_q.push_back(hl(32'hFFFF_FFFF, 32'h0000_0002));
    run_op("msubu", OP_MSUBU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, LAT + 1, 0);
    exp_q.push_back('{hw: 1'b0, lw: 1'b0, gw: 1'b1, hi: 32'd0, lo: 32'd0, gpr: 32'd0});
    run_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'hAAAA, 32'h5555, LAT + 1, 0);

    div_delay = 10;
    exp_q.push_back(hl(32'd2, 32'd14));
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 0, 0, 12, 1);
    div_delay = 3;
    exp_q.push_back(hl(32'd2, 32'd8));
    run_op("divu3", OP_DIVU, 32'd50, 32'd6, 0, 0, 5, 1);
    div_delay = 0;
    exp_q.push_back(hl(32'hFFFF_FFFE, 32'hFFFF_FFF2));
    run_op("div_fast", OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, 0, 2, 1);
    exp_q.push_back(hl(32'd5, 32'hFFFF_FFFF));
    run_op("div0", OP_DIV, 32'd5, 32'd0, 0, 0, 1, 0);

    // Flush in the third MUL_WAIT cycle.
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_MULT; rs_i = 32'd3; rt_i = 32'd4;
    @(negedge clk_i); #1;
    chk("fm_signed", mul_signed_o, 1);
    chk("fm_ce", mul_ce_o, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fm_sclr", mul_sclr_o, 1);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("fm_idle", busy_o, 0);
    chk("fm_sclr_idle", mul_sclr_o, 0);
    repeat (8) @(negedge clk_i);

    // Flush in DIV_WAIT.
    div_delay = 10;
    start_i = 1'b1; op_i = OP_DIVU; rs_i = 32'd100; rt_i = 32'd7;
    @(negedge clk_i); #1;
    chk("fd_start", div_start_o, 1);
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fd_abort", div_abort_o, 1);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("fd_idle", busy_o, 0);
    repeat (14) @(negedge clk_i);

    // Flush on the accept edge.
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MULT;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("fa_idle", busy_o, 0);

    // Flush in DONE (divide by zero reaches DONE one cycle after accept).
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIV; rs_i = 32'd9; rt_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fdone_busy", busy_o, 1);
    chk("fdone_we", {hi_we_o, lo_we_o, gpr_we_o}, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("fdone_idle", busy_o, 0);

    // Asynchronous reset in DIV_WAIT.
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; rs_i = 32'd77; rt_i = 32'd5;
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk("ar_pre_busy", busy_o, 1);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("ar_busy", busy_o, 0);
    chk("ar_stall", stall_o, 0);
    chk("ar_opnds", {div_a_o, mul_b_o}, 0);
    chk("ar_ctrl", {div_start_o, div_abort_o, div_signed_o, mul_ce_o, mul_sclr_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (14) @(negedge clk_i);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
